rmii_rx_framer: RTL

Upstream neighbour of the dibit FIFO in the Ethernet receive path. It samples the RMII receive interface (rxd, crs_dv, rx_er) on the 50 MHz reference clock and strips the preamble and SFD. It then writes each payload dibit into the FIFO via a w_en/data_out write port. It also reports per-frame status: completion, byte length and error flags.

---
 rtl/rmii_rx_framer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/rmii_rx_framer.sv
// rmii_rx_framer
// Receives frames from an RMII PHY, strips preamble and SFD, and pushes each
// payload dibit into a downstream dibit FIFO. Per-frame status (length and
// error flags) is reported with a one-cycle frame_done pulse.
//
// Ports:
//   clk           50 MHz RMII reference clock, all logic on posedge
//   rst           asynchronous active-high reset
//   crs_dv        RMII carrier sense / data valid
//   rxd[1:0]      RMII receive dibit, rxd[0] is the earlier bit
//   rx_er         RMII receive error
//   fifo_full     full flag from the downstream FIFO
//   w_en          FIFO write strobe, one dibit per high cycle
//   data_out[1:0] dibit to the FIFO, valid with w_en, held otherwise
//   frame_active  high from SFD acceptance until frame end or drop
//   frame_done    one-cycle pulse at frame end, status valid with it
//   frame_len     payload byte count (written dibits / 4)
//   err_overflow  a write was refused because the FIFO was full
//   err_align     written dibit count not a multiple of 4
//   err_rx        rx_er seen during payload
//   err_long      frame exceeded MAX_BYTES
module rmii_rx_framer #(
  parameter int MIN_PREAMBLE = 8,
  parameter int MAX_BYTES    = 1518,
  parameter int END_GAP      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        crs_dv,
  input  logic [1:0]  rxd,
  input  logic        rx_er,
  input  logic        fifo_full,
  output logic        w_en,
  output logic [1:0]  data_out,
  output logic        frame_active,
  output logic        frame_done,
  output logic [15:0] frame_len,
  output logic        err_overflow,
  output logic        err_align,
  output logic        err_rx,
  output logic        err_long
);

  localparam logic [4:0]  MIN_PRE = 5'(MIN_PREAMBLE);
  localparam logic [13:0] MAX_DIB = 14'(MAX_BYTES * 4);
  localparam logic [1:0]  GAP_END = 2'(END_GAP);

  typedef enum logic [2:0] {IDLE, PRE, DATA, DONE, DROP} state_t;

  state_t      state, state_next;

  logic        s_crs;
  logic [1:0]  s_rxd;
  logic        s_er;

  logic [4:0]  pre_cnt;
  logic [1:0]  gap_cnt;
  logic [13:0] dib_cnt;

  logic        wr;
  logic        start;
  logic        set_ovf;
  logic        set_long;
  logic        gap_hit;

  function automatic logic [13:0] sat_inc14(input logic [13:0] v);
    return (v == 14'h3FFF) ? v : v + 14'd1;
  endfunction

  function automatic logic [4:0] sat_inc5(input logic [4:0] v);
    return (v == 5'h1F) ? v : v + 5'd1;
  endfunction

  // Stage 0: register the RMII pins; every decision below uses these copies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_crs <= 1'b0;
      s_rxd <= 2'b00;
      s_er  <= 1'b0;
    end else begin
      s_crs <= crs_dv;
      s_rxd <= rxd;
      s_er  <= rx_er;
    end
  end

  // This low sample completes the end-of-frame gap.
  assign gap_hit = !s_crs && ((gap_cnt + 2'd1) == GAP_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    wr         = 1'b0;
    start      = 1'b0;
    set_ovf    = 1'b0;
    set_long   = 1'b0;
    case (state)
      IDLE: begin
        if (s_crs && s_rxd == 2'b01) state_next = PRE;
      end
      PRE: begin
        if (!s_crs) begin
          state_next = IDLE;
        end else if (s_rxd == 2'b01) begin
          state_next = PRE;
        end else if (s_rxd == 2'b11 && pre_cnt >= MIN_PRE) begin
          state_next = DATA;
          start      = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      DATA: begin
        if (s_crs) begin
          if (fifo_full) begin
            set_ovf    = 1'b1;
            state_next = DROP;
          end else if (dib_cnt >= MAX_DIB) begin
            set_long   = 1'b1;
            state_next = DROP;
          end else begin
            wr = 1'b1;
          end
        end else if (gap_hit) begin
          state_next = DONE;
        end
      end
      DROP: begin
        if (gap_hit) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Stage 1: counters, FIFO write port and frame status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt      <= 5'd0;
      gap_cnt      <= 2'd0;
      dib_cnt      <= 14'd0;
      w_en         <= 1'b0;
      data_out     <= 2'b00;
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
      frame_len    <= 16'd0;
      err_overflow <= 1'b0;
      err_align    <= 1'b0;
      err_rx       <= 1'b0;
      err_long     <= 1'b0;
    end else begin
      // Preloading 1 in IDLE accounts for the dibit that triggers IDLE->PRE.
      if (state == IDLE)
        pre_cnt <= 5'd1;
      else if (state == PRE && s_rxd == 2'b01)
        pre_cnt <= sat_inc5(pre_cnt);

      if (state == DATA || state == DROP)
        gap_cnt <= s_crs ? 2'd0 : gap_cnt + 2'd1;
      else
        gap_cnt <= 2'd0;

      if (start)
        dib_cnt <= 14'd0;
      else if (wr)
        dib_cnt <= sat_inc14(dib_cnt);

      w_en <= wr;
      if (wr) data_out <= s_rxd;

      frame_active <= (state_next == DATA);
      frame_done   <= (state_next == DONE);

      if (start) begin
        frame_len    <= 16'd0;
        err_overflow <= 1'b0;
        err_align    <= 1'b0;
        err_rx       <= 1'b0;
        err_long     <= 1'b0;
      end else begin
        if (set_ovf)                err_overflow <= 1'b1;
        if (set_long)               err_long     <= 1'b1;
        if (state == DATA && s_er)  err_rx       <= 1'b1;
        // The transition cycle into DONE never writes, so dib_cnt is final.
        if (state_next == DONE) begin
          frame_len <= {4'd0, dib_cnt[13:2]};
          err_align <= |dib_cnt[1:0];
        end
      end
    end
  end

endmodule
